// File: rtl/sram_responder_if.sv
// Core-side SRAM-style bus: instruction fetch port and data load/store port.
// The core drives the master modport; sram_responder sits on the slave modport.
interface sram_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_responder.sv
// Shared single-array SRAM responder for the core's fetch and data ports with kseg0/kseg1
// translation. Define SRAM_RESPONDER_MMIO_EN to add the LED register and timer window.
module sram_responder #(
    parameter int ADDR_W = 14,
    parameter int LED_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    sram_responder_if.slave   bus,
    output logic [LED_W-1:0]  led,
    output logic              bus_err
);
    localparam int DEPTH = 1 << ADDR_W;

    function automatic logic [31:0] va_to_pa(input logic [31:0] va);
        logic [31:0] pa;
        if (va[31:30] == 2'b10) begin
            pa = {3'b000, va[28:0]};
        end else begin
            pa = va;
        end
        return pa;
    endfunction

    function automatic logic in_ram(input logic [31:0] pa);
        return (pa >> (ADDR_W + 2)) == 32'd0;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return r;
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       inst_pa_s, data_pa_s;
    logic [ADDR_W-1:0] inst_idx_s, data_idx_s;
    logic              inst_ok_s, data_ok_s, mem_we_s;
    logic [31:0]       inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              unused_s;

    assign inst_pa_s  = va_to_pa(bus.inst_sram_addr);
    assign data_pa_s  = va_to_pa(bus.data_sram_addr);
    assign inst_idx_s = inst_pa_s[ADDR_W+1:2];
    assign data_idx_s = data_pa_s[ADDR_W+1:2];
    assign inst_ok_s  = in_ram(inst_pa_s);
    assign data_ok_s  = in_ram(data_pa_s);
    assign unused_s   = ^{bus.inst_sram_wen, bus.inst_sram_wdata, inst_pa_s[1:0], data_pa_s[1:0]};

`ifdef SRAM_RESPONDER_MMIO_EN
    localparam logic [31:0] LED_PA   = 32'h1FAF_F000;
    localparam logic [31:0] TIMER_PA = 32'h1FAF_E000;

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      timer_q, timer_d, led_word_s;
    logic             data_win_s;

    assign data_win_s = (data_pa_s[31:16] == 16'h1FAF);
    assign led_word_s = 32'(led_q);
`endif

    // Next-state for read data, sticky error, RAM write enable and MMIO registers
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        bus_err_d    = bus_err_q;
        mem_we_s     = 1'b0;
`ifdef SRAM_RESPONDER_MMIO_EN
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
`endif

        if (!bus.inst_sram_en) begin
            inst_rdata_d = inst_rdata_q;
        end else if (inst_ok_s) begin
            inst_rdata_d = mem_q[inst_idx_s];
        end else begin
            // Out-of-range fetch (including the MMIO window) returns a NOP
            inst_rdata_d = 32'h0000_0000;
            bus_err_d    = 1'b1;
        end

        if (!bus.data_sram_en) begin
            data_rdata_d = data_rdata_q;
        end
`ifdef SRAM_RESPONDER_MMIO_EN
        else if (data_win_s) begin
            if (bus.data_sram_wen == 4'b0000) begin
                case (data_pa_s)
                    LED_PA:   data_rdata_d = led_word_s;
                    TIMER_PA: data_rdata_d = timer_d;
                    default:  data_rdata_d = 32'h0000_0000;
                endcase
            end else begin
                case (data_pa_s)
                    LED_PA:   led_d = LED_W'(merge_bytes(led_word_s, bus.data_sram_wdata,
                                                         {2'b00, bus.data_sram_wen[1:0]}));
                    TIMER_PA: begin
                        if (bus.data_sram_wen == 4'b1111) begin
                            timer_d = bus.data_sram_wdata;
                        end else begin
                            timer_d = timer_q + 32'd1;
                        end
                    end
                    default:  led_d = led_q;
                endcase
            end
        end
`endif
        else if (data_ok_s) begin
            if (bus.data_sram_wen != 4'b0000) begin
                mem_we_s = 1'b1;
            end else begin
                data_rdata_d = mem_q[data_idx_s];
            end
        end else begin
            bus_err_d = 1'b1;
            if (bus.data_sram_wen == 4'b0000) begin
                data_rdata_d = 32'h0000_0000;
            end else begin
                data_rdata_d = data_rdata_q;
            end
        end
    end

    // Byte-lane RAM write; blocked during reset, contents are never cleared
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_q[data_idx_s] <= merge_bytes(mem_q[data_idx_s], bus.data_sram_wdata,
                                             bus.data_sram_wen);
        end
    end

    // Response and error registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_rdata_q <= 32'h0000_0000;
            data_rdata_q <= 32'h0000_0000;
            bus_err_q    <= 1'b0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

`ifdef SRAM_RESPONDER_MMIO_EN
    // LED register and free-running timer
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q   <= {LED_W{1'b0}};
            timer_q <= 32'h0000_0000;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
        end
    end

    assign led = led_q;
`else
    assign led = {LED_W{1'b0}};
`endif

    assign bus.inst_sram_rdata = inst_rdata_q;
    assign bus.data_sram_rdata = data_rdata_q;
    assign bus_err             = bus_err_q;
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's two SRAM-style master ports (instruction fetch and data load/store).
- Does kseg0/kseg1 address translation and serves both ports from one shared word array with byte write enables and fixed 1-cycle read latency.
- Optionally decodes a small MMIO window holding an LED register and a free-running timer.
- Sits in the SoC top directly beside the core; it is the far end of the core's inst_sram_* and data_sram_* signals.

Parameters:
- ADDR_W, 14: word-index width; the RAM holds 2^ADDR_W 32-bit words (default 64 KB).
- LED_W, 16: width of the LED register and output.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- inst_sram_en  in  1  fetch request valid
- inst_sram_wen  in  4  ignored; the instruction port is read-only
- inst_sram_addr  in  32  virtual fetch address, word aligned
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  fetch data, valid 1 cycle after the request
- data_sram_en  in  1  data access valid
- data_sram_wen  in  4  byte write enables; 0000 = read
- data_sram_addr  in  32  virtual data address, word aligned
- data_sram_wdata  in  32  store data, lanes selected by wen
- data_sram_rdata  out  32  load data, valid 1 cycle after the request
- led  out  LED_W  LED register contents
- bus_err  out  1  sticky flag: set on an out-of-range access

Behaviour:
- Address translation, applied to each port independently:
  - va[31:30]==2'b10 (kseg0/kseg1): pa = {3'b000, va[28:0]}.
  - Otherwise: pa = va.
- RAM region:
  - In range when pa[31:ADDR_W+2]==0.
  - Word index = pa[ADDR_W+1:2]; pa[1:0] is ignored.
- Instruction port:
  - en=1, in range: inst_sram_rdata <= mem[idx] at the next edge.
  - en=1, out of range: rdata <= 32'h0 (NOP) and bus_err is set.
  - en=0: rdata holds its previous value.
- Data port:
  - en=1, wen!=0, in range: each byte lane i with wen[i]=1 is written at the edge; data_sram_rdata holds.
  - en=1, wen==0, in range: data_sram_rdata <= mem[idx] at the next edge.
  - en=0: rdata holds.
  - Out-of-range write is dropped and sets bus_err. Out-of-range read returns 0 and sets bus_err.
  - The MMIO window is exempt from these out-of-range rules when MMIO is compiled in.
- Latency: exactly 1 cycle on both ports. There is no stall or handshake; a request is accepted every cycle.
- Simultaneous events:
  - Instruction read and data write to the same word in the same cycle: the instruction port returns the OLD word (read-before-write).
  - A data read in the cycle after a write to the same word returns the NEW word.
- Partial writes: lanes with wen[i]=0 are unchanged.
  - Example: wen=4'b0011 with wdata=32'hAABBCCDD onto 32'h11223344 gives 32'h1122CCDD.
- Reset (rst==0 at the edge):
  - inst_sram_rdata=0, data_sram_rdata=0, led=0, bus_err=0, timer=0.
  - All writes are suppressed while rst==0. RAM contents are not cleared.
  - Reset mid-stream: the first request after rst rises is serviced normally, with 1-cycle latency.
- bus_err stays high until reset once set.

Optional Feature:
- Macro: SRAM_RESPONDER_MMIO_EN.
- Defined (data port only):
  - pa==32'h1FAF_F000: LED register. Write updates led from byte lanes wen[1:0]; read returns {zero-extend, led}.
  - pa==32'h1FAF_E000: timer. A 32-bit counter that increments every cycle out of reset. A full-word write (wen=4'b1111) loads wdata, and the counter resumes incrementing from wdata+1 on the following cycle. A read returns the counter value sampled at the request edge.
  - Any other pa in 32'h1FAF_0000..32'h1FAF_FFFF: reads return 0, writes are dropped, bus_err is not set.
  - Instruction fetches into the window: return 0 and set bus_err.
- Undefined:
  - The window is treated as ordinary out-of-range space (bus_err set).
  - led is tied to 0 and there is no timer logic.

Test Plan:
- Write 32'hDEADBEEF via va 32'h8000_0010 with wen=1111, then read va 32'hA000_0010 -> data_sram_rdata=32'hDEADBEEF one cycle after the read request (kseg0/kseg1 alias).
- Word holds 32'h11223344; write wen=0011, wdata=32'hAABBCCDD; read -> 32'h1122CCDD.
- Same cycle: fetch of idx 4 and data write 32'h5 to idx 4 -> inst_sram_rdata returns the old word; a fetch on the next cycle returns 32'h5.
- Data read of va 32'h0010_0000 with ADDR_W=14 -> rdata=0 and bus_err=1 from the next cycle; bus_err stays 1 until rst=0, then 0.
- Issue a write while rst=0, release reset, read the same word -> pre-write contents; rdata outputs were 0 during reset.
- MMIO_EN:
  - Write 32'h0000_00A5 to 32'hBFAF_F000 -> led=16'h00A5 next cycle.
  - Write 32'h100 to the timer, then read 3 cycles later -> 32'h103.
